fifo_stream_reader: RTL

Read-side controller for the synchronous FIFO. Drains the FIFO through its read-enable/empty interface and presents words on a valid/ready output stream with full throughput. Absorbs the FIFO's one-cycle registered read latency in a 2-entry output buffer, so downstream backpressure never loses data.

---
 rtl/fifo_stream_reader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side controller: drains a synchronous FIFO into a valid/ready stream via a 2-entry skid buffer.
// Optional FIFO_RD_CNT_EN compiles in the rd_count port and its 16-bit delivered-word counter.
module fifo_stream_reader #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_r_en,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [15:0]       rd_count
`endif
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } occ_e;

    occ_e              occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] buf_q [2];
    logic [DATA_W-1:0] buf_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;

    logic       pop;
    logic       push;
    logic [1:0] occ_cnt;
    logic [1:0] level;

    assign m_valid = (occ_q != StEmpty);
    assign m_data  = buf_q[rd_ptr_q];
    assign pop     = m_valid & m_ready;
    // A word landing during a flush is discarded, so it is not a push.
    assign push    = inflight_q & ~flush;

    assign occ_cnt = occ_q;
    // Slots committed after this edge; never exceeds 3 since occ + inflight <= 2.
    assign level   = occ_cnt + {1'b0, inflight_q} - {1'b0, pop};

    assign fifo_r_en = ~reset & ~flush & ~fifo_empty & (level < 2'd2);

    always_comb begin
        occ_d      = occ_q;
        inflight_d = fifo_r_en;
        buf_d      = buf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (push) begin
            buf_d[wr_ptr_q] = fifo_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        if (flush) begin
            occ_d    = StEmpty;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else if (push && !pop) begin
            case (occ_q)
                StEmpty: occ_d = StOne;
                StOne:   occ_d = StFull;
                default: occ_d = StFull;
            endcase
        end else if (pop && !push) begin
            case (occ_q)
                StFull:  occ_d = StOne;
                StOne:   occ_d = StEmpty;
                default: occ_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q      <= StEmpty;
            inflight_q <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf_q      <= buf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

`ifdef FIFO_RD_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Pops are counted even in a flush cycle; the word was already handed off.
    always_comb begin
        cnt_d = cnt_q;
        if (pop) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd_count = cnt_q;
`endif

endmodule
